// File: rtl/gate_check_pkg.sv
// gate_check_pkg
// Shared definitions for the gate exerciser family: the sequencer state
// encoding, parameter-legality limits and a width helper for settle timers.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Legal parameter ranges for exercisers built on this package.
  localparam int N_IN_MAX   = 4;
  localparam int SETTLE_MIN = 1;

  // Counter width needed to hold a settle count of 0..settle.
  function automatic int timer_width(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer
// Loadable down-counter used to hold a stimulus stable for a fixed number of
// cycles. Load has priority over counting; the count stops at zero, where
// expire is asserted.
//
// Ports:
//   clk         clock, all state on rising edge
//   reset       synchronous active-high reset (count -> 0)
//   load        load load_value on the next edge
//   load_value  value to load
//   en          decrement by one when nonzero
//   expire      high while the count is zero
module settle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             expire
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (en && (count_reg != '0)) begin
      count_next = count_reg - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expire = (count_reg == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Synthesizable exerciser for a combinational gate: walks dut_in through all
// 2**N_IN vectors, holds each for SETTLE cycles, samples dut_out for one cycle
// and compares it against the TRUTH table. Reports pass/fail, a mismatch count
// and the first failing vector.
//
// Ports:
//   clk               clock, all state on rising edge
//   reset             synchronous active-high reset
//   start             begin a run (honoured only in IDLE or DONE)
//   dut_in            vector driven to the gate under test
//   dut_out           gate output, combinational from dut_in
//   busy              run in progress
//   done              run finished, held until next accepted start or reset
//   pass              done and no mismatches
//   err_count         mismatches in the current or last run
//   first_fail_valid  at least one mismatch recorded
//   first_fail_vec    vector of the first mismatch (0 when none)
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                       N_IN   = 2,
  parameter logic [(1 << N_IN)-1:0]   TRUTH  = 4'b0111,
  parameter int                       SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int              CNT_W       = timer_width(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = '1;

  if ((N_IN < 1) || (N_IN > N_IN_MAX)) begin : g_bad_n_in
    $error("gate_truth_checker: N_IN out of range");
  end
  if (SETTLE < SETTLE_MIN) begin : g_bad_settle
    $error("gate_truth_checker: SETTLE below minimum");
  end

  state_t          state_reg, state_next;
  logic [N_IN-1:0] vec_reg, vec_next;
  logic [N_IN:0]   err_reg, err_next;
  logic            ffv_reg, ffv_next;
  logic [N_IN-1:0] ffvec_reg, ffvec_next;

  logic timer_load;
  logic timer_en;
  logic timer_expire;
  logic mismatch;

  settle_timer #(
    .WIDTH(CNT_W)
  ) u_settle_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(SETTLE_LOAD),
    .en        (timer_en),
    .expire    (timer_expire)
  );

  assign mismatch = dut_out ^ TRUTH[vec_reg];

  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    err_next   = err_reg;
    ffv_next   = ffv_reg;
    ffvec_next = ffvec_reg;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        done = (state_reg == DONE);
        if (start) begin
          // A start from DONE discards the previous run's results.
          state_next = DRIVE;
          vec_next   = '0;
          err_next   = '0;
          ffv_next   = 1'b0;
          ffvec_next = '0;
          timer_load = 1'b1;
        end
      end
      DRIVE: begin
        busy     = 1'b1;
        timer_en = 1'b1;
        if (timer_expire) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        busy = 1'b1;
        if (mismatch) begin
          err_next = err_reg + (N_IN + 1)'(1);
          if (!ffv_reg) begin
            ffv_next   = 1'b1;
            ffvec_next = vec_reg;
          end
        end
        // Last vector found by compare so vec never has to wrap.
        if (vec_reg == LAST_VEC) begin
          state_next = DONE;
        end else begin
          vec_next   = vec_reg + N_IN'(1);
          timer_load = 1'b1;
          state_next = DRIVE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_reg   <= '0;
      err_reg   <= '0;
      ffv_reg   <= 1'b0;
      ffvec_reg <= '0;
    end else begin
      vec_reg   <= vec_next;
      err_reg   <= err_next;
      ffv_reg   <= ffv_next;
      ffvec_reg <= ffvec_next;
    end
  end

  assign dut_in           = (state_reg == IDLE) ? '0 : vec_reg;
  assign pass             = (state_reg == DONE) && (err_reg == '0);
  assign err_count        = err_reg;
  assign first_fail_valid = ffv_reg;
  assign first_fail_vec   = ffvec_reg;

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker
// Three checker instances (NOT from NAND, NAND2 with SETTLE=1, NAND2 with
// SETTLE=3), each driving a table-defined gate held in gate_tbl. Expected
// results come from a per-run model that diffs the gate table against the
// truth table and predicts the vector schedule arithmetically.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start [3];
  logic [3:0] gate_tbl [3];

  int         cfg_n [3];
  int         cfg_s [3];
  logic [3:0] cfg_truth [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Instance 0: NOT (N_IN=1, TRUTH=2'b01, SETTLE=1)
  logic [0:0] din0;
  logic       dout0, busy0, done0, pass0, ffv0;
  logic [1:0] err0;
  logic [0:0] ffvec0;
  // Instance 1: NAND2 defaults
  logic [1:0] din1;
  logic       dout1, busy1, done1, pass1, ffv1;
  logic [2:0] err1;
  logic [1:0] ffvec1;
  // Instance 2: NAND2, SETTLE=3
  logic [1:0] din2;
  logic       dout2, busy2, done2, pass2, ffv2;
  logic [2:0] err2;
  logic [1:0] ffvec2;

  assign dout0 = gate_tbl[0][din0];
  assign dout1 = gate_tbl[1][din1];
  assign dout2 = gate_tbl[2][din2];

  gate_truth_checker #(.N_IN(1), .TRUTH(2'b01), .SETTLE(1)) u_not (
    .clk(clk), .reset(reset), .start(start[0]), .dut_in(din0), .dut_out(dout0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
  );

  gate_truth_checker u_nand (
    .clk(clk), .reset(reset), .start(start[1]), .dut_in(din1), .dut_out(dout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  gate_truth_checker #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(3)) u_nand_s3 (
    .clk(clk), .reset(reset), .start(start[2]), .dut_in(din2), .dut_out(dout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  // Uniform views of the three instances, zero-extended.
  logic [3:0] obs_din [3];
  logic [4:0] obs_err [3];
  logic [3:0] obs_ffvec [3];
  logic       obs_busy [3];
  logic       obs_done [3];
  logic       obs_pass [3];
  logic       obs_ffv [3];

  assign obs_din[0]   = {3'b0, din0};
  assign obs_din[1]   = {2'b0, din1};
  assign obs_din[2]   = {2'b0, din2};
  assign obs_err[0]   = {3'b0, err0};
  assign obs_err[1]   = {2'b0, err1};
  assign obs_err[2]   = {2'b0, err2};
  assign obs_ffvec[0] = {3'b0, ffvec0};
  assign obs_ffvec[1] = {2'b0, ffvec1};
  assign obs_ffvec[2] = {2'b0, ffvec2};
  assign obs_busy[0]  = busy0;
  assign obs_busy[1]  = busy1;
  assign obs_busy[2]  = busy2;
  assign obs_done[0]  = done0;
  assign obs_done[1]  = done1;
  assign obs_done[2]  = done2;
  assign obs_pass[0]  = pass0;
  assign obs_pass[1]  = pass1;
  assign obs_pass[2]  = pass2;
  assign obs_ffv[0]   = ffv0;
  assign obs_ffv[1]   = ffv1;
  assign obs_ffv[2]   = ffv2;

  // One complete run on instance idx against gate table 'gate'. Optionally
  // pulses start for one cycle after edge pulse_at (must be ignored).
  task automatic run_check(input int idx, input string name,
                           input logic [3:0] gate, input int pulse_at);
    int   nv, s, total, exp_err, exp_ff;
    bit   found;
    nv    = 1 << cfg_n[idx];
    s     = cfg_s[idx];
    total = nv * (s + 1);
    exp_err = 0;
    exp_ff  = 0;
    found   = 1'b0;
    for (int v = 0; v < nv; v++) begin
      if (gate[v] != cfg_truth[idx][v]) begin
        exp_err++;
        if (!found) begin
          found  = 1'b1;
          exp_ff = v;
        end
      end
    end
    gate_tbl[idx] = gate;

    @(negedge clk);
    start[idx] = 1'b1;
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
    // Accepting edge clears results and drops done.
    n_checks++;
    if (obs_err[idx] !== 5'd0 || obs_ffv[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s clear_at_start: err=%0d ffv=%b want err=0 ffv=0",
               name, obs_err[idx], obs_ffv[idx]);
    end

    for (int j = 0; j < total; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      n_checks++;
      if (obs_busy[idx] !== 1'b1 || obs_done[idx] !== 1'b0 || obs_pass[idx] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s run_flags@edge%0d: busy=%b done=%b pass=%b want 1/0/0",
                 name, j, obs_busy[idx], obs_done[idx], obs_pass[idx]);
      end
      n_checks++;
      if (obs_din[idx] !== 4'(j / (s + 1))) begin
        n_fail++;
        $display("FAIL %s dut_in@edge%0d: got %0d want %0d",
                 name, j, obs_din[idx], j / (s + 1));
      end
      start[idx] = (j == pulse_at) ? 1'b1 : 1'b0;
    end

    @(posedge clk);
    #1;
    start[idx] = 1'b0;
    n_checks++;
    if (obs_done[idx] !== 1'b1 || obs_busy[idx] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done@edge%0d: done=%b busy=%b want 1/0",
               name, total, obs_done[idx], obs_busy[idx]);
    end
    n_checks++;
    if (obs_pass[idx] !== (exp_err == 0)) begin
      n_fail++;
      $display("FAIL %s pass: got %b want %b", name, obs_pass[idx], exp_err == 0);
    end
    n_checks++;
    if (obs_err[idx] !== 5'(exp_err)) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d want %0d", name, obs_err[idx], exp_err);
    end
    n_checks++;
    if (obs_ffv[idx] !== found || obs_ffvec[idx] !== 4'(exp_ff)) begin
      n_fail++;
      $display("FAIL %s first_fail: got valid=%b vec=%0d want valid=%b vec=%0d",
               name, obs_ffv[idx], obs_ffvec[idx], found, exp_ff);
    end
    n_checks++;
    if (obs_din[idx] !== 4'(nv - 1)) begin
      n_fail++;
      $display("FAIL %s dut_in_hold: got %0d want %0d", name, obs_din[idx], nv - 1);
    end
    $display("run %s: gate=%b err=%0d pass=%b", name, gate, obs_err[idx], obs_pass[idx]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_din[i] !== 4'd0 || obs_busy[i] !== 1'b0 || obs_done[i] !== 1'b0 ||
          obs_pass[i] !== 1'b0 || obs_err[i] !== 5'd0 || obs_ffv[i] !== 1'b0 ||
          obs_ffvec[i] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_values inst%0d: din=%0d busy=%b done=%b pass=%b err=%0d ffv=%b ffvec=%0d want all 0",
                 i, obs_din[i], obs_busy[i], obs_done[i], obs_pass[i], obs_err[i],
                 obs_ffv[i], obs_ffvec[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_not_gate();
    run_check(0, "not_ok", 4'b0001, -1);
  endtask

  task automatic test_not_stuck0();
    run_check(0, "not_stuck0", 4'b0000, -1);
  endtask

  task automatic test_nand_fed_and();
    run_check(1, "nand_fed_and", 4'b1000, -1);
  endtask

  task automatic test_reset_mid_run();
    gate_tbl[2] = 4'b0111;
    @(negedge clk);
    start[2] = 1'b1;
    @(posedge clk);            // edge 0
    #1;
    start[2] = 1'b0;
    repeat (5) @(posedge clk); // edge 5
    #1;
    reset = 1'b1;
    @(posedge clk);            // edge 6
    #1;
    n_checks++;
    if (din2 !== 2'd0 || busy2 !== 1'b0 || done2 !== 1'b0 || pass2 !== 1'b0 ||
        err2 !== 3'd0 || ffv2 !== 1'b0 || ffvec2 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: din=%0d busy=%b done=%b pass=%b err=%0d ffv=%b ffvec=%0d want all 0",
               din2, busy2, done2, pass2, err2, ffv2, ffvec2);
    end
    @(negedge clk);
    reset = 1'b0;
    run_check(2, "after_reset", 4'b0111, -1);
  endtask

  task automatic test_start_while_busy();
    run_check(1, "busy_start_s1", 4'b0111, 3);
    run_check(2, "busy_start_s3", 4'b0110, 9);
  endtask

  task automatic test_restart_after_fail();
    run_check(1, "fail_run", 4'b1001, -1);
    run_check(1, "restart_fixed", 4'b0111, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      int         idx, total, pulse;
      logic [3:0] g;
      idx   = $urandom_range(0, 2);
      g     = 4'($urandom);
      if (cfg_n[idx] == 1) g[3:2] = 2'b00;
      total = (1 << cfg_n[idx]) * (cfg_s[idx] + 1);
      pulse = ($urandom_range(0, 1) == 1) ? $urandom_range(1, total - 1) : -1;
      run_check(idx, $sformatf("rand%0d_inst%0d", k, idx), g, pulse);
    end
  endtask

  initial begin
    cfg_n[0] = 1; cfg_s[0] = 1; cfg_truth[0] = 4'b0001;
    cfg_n[1] = 2; cfg_s[1] = 1; cfg_truth[1] = 4'b0111;
    cfg_n[2] = 2; cfg_s[2] = 3; cfg_truth[2] = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      start[i]    = 1'b0;
      gate_tbl[i] = cfg_truth[i];
    end
    reset = 1'b0;

    test_reset();
    test_not_gate();
    test_not_stuck0();
    test_nand_fed_and();
    test_reset_mid_run();
    test_start_while_busy();
    test_restart_after_fail();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
